// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift/rotate unit: op codes, FSM states, default widths.
package shift_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 4;

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_ROR = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_SRL;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational one-bit shift/rotate stage: produces the value after a single step of op.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] val,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves nxt unassigned (no latch).
    nxt = val;
    case (op)
      OP_ROL:  nxt = {val[WIDTH-2:0], val[WIDTH-1]};
      OP_ROR:  nxt = {val[0], val[WIDTH-1:1]};
      OP_SLL:  nxt = {val[WIDTH-2:0], 1'b0};
      OP_SRA:  nxt = {val[WIDTH-1], val[WIDTH-1:1]};
      OP_SRL:  nxt = {1'b0, val[WIDTH-1:1]};
      default: nxt = val;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift/rotate sequencer: one single-bit step per clock until the count is spent.
// Optional SHIFT_SEQ_EARLY_TERM_EN finishes early once further steps cannot change the value.
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] cnt,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] out
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] step_val;
  logic             settled;
  logic             legal;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .val (val_q),
    .op  (op_q),
    .nxt (step_val)
  );

`ifdef SHIFT_SEQ_EARLY_TERM_EN
  // Fixed points of the logical/arithmetic shifts; rotates never settle.
  assign settled = (((op_q == OP_SLL) || (op_q == OP_SRL)) && (val_q == '0)) ||
                   ((op_q == OP_SRA) && ((val_q == '0) || (val_q == '1)));
`else
  assign settled = 1'b0;
`endif

  assign legal = op_legal(op);

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    op_d    = op_q;
    rem_d   = rem_q;
    out_d   = out_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          val_d = in;
          op_d  = op;
          rem_d = cnt;
          err_d = !legal;
          if (!legal || (cnt == '0)) begin
            out_d   = in;
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (settled) begin
          out_d   = val_q;
          state_d = ST_DONE;
        end else begin
          val_d = step_val;
          if (rem_q != '0) rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            out_d   = step_val;
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      val_q   <= '0;
      op_q    <= OP_ROL;
      rem_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy  = (state_q == ST_SHIFT);
  assign done  = (state_q == ST_DONE);
  assign err   = err_q;
  assign out   = out_q;

endmodule
